// File: rtl/ldpc_cn_minsum.sv
// ---------------------------------------------------------------------------
// ldpc_cn_minsum
//
// Min-sum check-node processor for LDPC decoding. It consumes one check node's
// int8 variable-to-check messages, tracks min1, min2, the index of min1 and
// the sign parity, and then streams the check-to-variable messages back out.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer keeps its valid and payload
// stable until that transfer. in_ready_o and out_valid_o depend only on
// registered state.
//
// Optional build macro:
//   LDPC_CN_OFFSET_EN - offset min-sum. In EMIT each magnitude is reduced by
//                       one, stopping at zero, before the sign is applied.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   start_i      one-cycle pulse that begins a node; honoured only in IDLE
//   cfg_deg_i    node degree, sampled with start_i (0 = ignore,
//                clamped to MAX_DEG)
//   in_valid_i   variable-to-check message valid
//   in_ready_o   high throughout ACCUM
//   in_msg_i     signed int8 variable-to-check message
//   out_valid_o  high throughout EMIT
//   out_ready_i  downstream ready
//   out_msg_o    signed int8 check-to-variable message (-127..127)
//   out_idx_o    edge index of out_msg_o
//   busy_o       high in ACCUM and EMIT
//   done_o       one-cycle pulse in the IDLE cycle after the last output
//   dbg_state_o  current FSM state (0 IDLE, 1 ACCUM, 2 EMIT)
// ---------------------------------------------------------------------------
module ldpc_cn_minsum #(
    parameter int MAX_DEG = 32,
    parameter int IDX_W   = $clog2(MAX_DEG)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [IDX_W:0]   cfg_deg_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_msg_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [7:0]       out_msg_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    localparam logic [IDX_W:0] DEG_MAX = (IDX_W + 1)'(MAX_DEG);

    state_t             state_q, state_d;
    logic [IDX_W:0]     deg_q;
    logic [IDX_W:0]     cnt_q;
    logic [6:0]         min1_q, min2_q;
    logic [IDX_W-1:0]   idx1_q;
    logic               parity_q;
    logic [MAX_DEG-1:0] sign_q;
    logic               done_q;

    logic               start_ok;
    logic               in_fire, out_fire;
    logic               last_cnt;
    logic [IDX_W-1:0]   cnt_idx;
    logic [IDX_W:0]     deg_clamp;
    logic [7:0]         in_neg;
    logic [6:0]         in_mag;
    logic [6:0]         emit_mag;
    logic [6:0]         emit_mag_adj;
    logic               emit_sign;
    logic [7:0]         emit_pos, emit_neg;

    // ------------------------------------------------------------------
    // Control decodes
    // ------------------------------------------------------------------
    assign start_ok  = (state_q == S_IDLE) && start_i && (cfg_deg_i != '0);
    assign in_fire   = (state_q == S_ACCUM) && in_valid_i;
    assign out_fire  = (state_q == S_EMIT) && out_ready_i;
    // cnt_q never reaches deg_q in ACCUM/EMIT, so the low bits address edges.
    assign cnt_idx   = cnt_q[IDX_W-1:0];
    assign last_cnt  = (cnt_q == (deg_q - 1'b1));
    assign deg_clamp = (cfg_deg_i > DEG_MAX) ? DEG_MAX : cfg_deg_i;

    // |in_msg_i| as 7 bits; -128 has no positive twin and saturates to 127.
    assign in_neg = -in_msg_i;
    always_comb begin
        in_mag = in_msg_i[6:0];
        if (in_msg_i == 8'h80) begin
            in_mag = 7'd127;
        end else if (in_msg_i[7]) begin
            in_mag = in_neg[6:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok)             state_d = S_ACCUM;
            S_ACCUM: if (in_fire && last_cnt)  state_d = S_EMIT;
            S_EMIT:  if (out_fire && last_cnt) state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deg_q    <= '0;
            cnt_q    <= '0;
            min1_q   <= '0;
            min2_q   <= '0;
            idx1_q   <= '0;
            parity_q <= 1'b0;
            sign_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        deg_q    <= deg_clamp;
                        cnt_q    <= '0;
                        min1_q   <= 7'd127;
                        min2_q   <= 7'd127;
                        idx1_q   <= '0;
                        parity_q <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (in_fire) begin
                        sign_q[cnt_idx] <= in_msg_i[7];
                        parity_q        <= parity_q ^ in_msg_i[7];
                        // Strict compares: on a tie the earlier edge keeps
                        // min1 and the tied value becomes min2.
                        if (in_mag < min1_q) begin
                            min2_q <= min1_q;
                            min1_q <= in_mag;
                            idx1_q <= cnt_idx;
                        end else if (in_mag < min2_q) begin
                            min2_q <= in_mag;
                        end
                        cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_fire) begin
                        if (last_cnt) begin
                            cnt_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output message: edge idx1 sees min2, every other edge sees min1.
    // The sign is the parity of all other edges, i.e. total parity with
    // this edge's own sign removed.
    // ------------------------------------------------------------------
    assign emit_mag  = (cnt_idx == idx1_q) ? min2_q : min1_q;
    assign emit_sign = parity_q ^ sign_q[cnt_idx];

`ifdef LDPC_CN_OFFSET_EN
    assign emit_mag_adj = (emit_mag == 7'd0) ? 7'd0 : emit_mag - 7'd1;
`else
    assign emit_mag_adj = emit_mag;
`endif

    // A zero magnitude negates to zero, so no -0 can appear.
    assign emit_pos = {1'b0, emit_mag_adj};
    assign emit_neg = -emit_pos;

    assign out_msg_o   = (state_q == S_EMIT) ? (emit_sign ? emit_neg : emit_pos) : 8'd0;
    assign out_idx_o   = (state_q == S_EMIT) ? cnt_idx : '0;
    assign out_valid_o = (state_q == S_EMIT);
    assign in_ready_o  = (state_q == S_ACCUM);
    assign busy_o      = (state_q == S_ACCUM) || (state_q == S_EMIT);
    assign done_o      = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ldpc_cn_minsum.sv
// ---------------------------------------------------------------------------
// tb_ldpc_cn_minsum
//
// Directed bench for ldpc_cn_minsum. Expected outputs are hand-derived for
// plain min-sum; ev() reduces each magnitude by one when LDPC_CN_OFFSET_EN
// is defined so the same tables cover the offset build.
// ---------------------------------------------------------------------------
module tb_ldpc_cn_minsum;

    localparam int MAX_DEG = 32;
    localparam int IDX_W   = 5;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [IDX_W:0]   cfg_deg;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_msg;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_msg;
    logic [IDX_W-1:0] out_idx;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    ldpc_cn_minsum #(.MAX_DEG(MAX_DEG), .IDX_W(IDX_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .cfg_deg_i   (cfg_deg),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_msg_i    (in_msg),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_msg_o   (out_msg),
        .out_idx_o   (out_idx),
        .busy_o      (busy),
        .done_o      (done),
        .dbg_state_o (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- helpers ----------------
    function automatic logic [7:0] ev(input int v);
        int m;
        m = (v < 0) ? -v : v;
`ifdef LDPC_CN_OFFSET_EN
        if (m > 0) m = m - 1;
`endif
        ev = (v < 0) ? 8'(-m) : 8'(m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks (entered and left at a negedge) -------
    task automatic start_node(input logic [IDX_W:0] deg);
        start   = 1'b1;
        cfg_deg = deg;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        cfg_deg = '0;
    endtask

    task automatic send(input logic [7:0] m);
        int b;
        b        = 0;
        in_valid = 1'b1;
        in_msg   = m;
        while (!in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) begin
            chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic recv(input string tag, input int idx, input logic [7:0] exp);
        int b;
        b         = 0;
        out_ready = 1'b1;
        while (!out_valid && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) begin
            chk({tag, "_valid_timeout"}, {31'd0, out_valid}, 32'd1);
        end else begin
            chk({tag, "_idx"}, {27'd0, out_idx}, idx);
            chk({tag, "_msg"}, {24'd0, out_msg}, {24'd0, exp});
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_deg   = '0;
        in_valid  = 1'b0;
        in_msg    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_state",     {30'd0, dbg_state}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_out_msg",   {24'd0, out_msg},   32'd0);

        // Degree 0 is ignored
        start_node(6'd0);
        chk("deg0_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("deg0_busy_later", {31'd0, busy}, 32'd0);

        // Basic node with backpressure on idx1 and a stray start in EMIT.
        // mags 5,3,7,10 -> min1=3@1, min2=5, parity 0.
        start_node(6'd4);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        send(8'd5);
        send(8'hFD);
        send(8'd7);
        send(8'hF6);
        in_valid = 1'b0;
        chk("basic_latency", {31'd0, out_valid}, 32'd1);
        recv("basic0", 0, ev(3));
        out_ready = 1'b0;
        start     = 1'b1;
        cfg_deg   = 6'd2;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_msg",   {24'd0, out_msg},   {24'd0, ev(-5)});
            chk("bp_idx",   {27'd0, out_idx},   32'd1);
            @(negedge clk);
            start   = 1'b0;
            cfg_deg = '0;
        end
        recv("basic1", 1, ev(-5));
        recv("basic2", 2, ev(3));
        recv("basic3", 3, ev(-3));
        check_done("basic");
        chk("emit_start_ignored", {30'd0, dbg_state}, 32'd0);

        // Tie: 4,4,9 -> min1=4@0, min2=4
        start_node(6'd3);
        send(8'd4);
        send(8'd4);
        send(8'd9);
        in_valid = 1'b0;
        recv("tie0", 0, ev(4));
        recv("tie1", 1, ev(4));
        recv("tie2", 2, ev(4));
        check_done("tie");

        // Saturation: -128 -> 127 (ties the initial 127, min1 stays 127@0),
        // then 1 -> min1=1@1, min2=127, parity 1.
        // idx0: mag 1, sign 1^1=0 -> 1; idx1: mag 127, sign 1^0=1 -> -127.
        start_node(6'd2);
        send(8'h80);
        send(8'd1);
        in_valid = 1'b0;
        recv("sat0", 0, ev(1));
        recv("sat1", 1, ev(-127));
        check_done("sat");

        // Degree 1: single output is +127
        start_node(6'd1);
        send(8'h9C);
        in_valid = 1'b0;
        recv("deg1", 0, ev(127));
        check_done("deg1");

        // Reset mid-ACCUM after 2 of 4 inputs
        start_node(6'd4);
        send(8'd5);
        send(8'hFD);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_state",     {30'd0, dbg_state}, 32'd0);
        chk("mrst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_busy",      {31'd0, busy},      32'd0);
        chk("mrst_out_idx",   {27'd0, out_idx},   32'd0);
        // 6,-2 -> min1=2@1, min2=6, parity 1
        start_node(6'd2);
        send(8'd6);
        send(8'hFE);
        in_valid = 1'b0;
        recv("post0", 0, ev(-2));
        recv("post1", 1, ev(6));
        check_done("post");

        // cfg_deg = MAX_DEG+1 -> exactly MAX_DEG accepted.
        // Inputs 1..32: min1=1@0, min2=2, parity 0.
        start_node(6'd33);
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        for (int i = 0; i < 45; i++) begin
            logic rdy;
            in_msg = 8'(acc + 1);
            rdy    = in_ready;
            @(posedge clk);
            if (rdy) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("max_accepted", acc, MAX_DEG);
        for (int k = 0; k < MAX_DEG; k++) begin
            recv("max", k, (k == 0) ? ev(2) : ev(1));
        end
        check_done("max");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
